// File: rtl/axi_slv_mem_pkg.sv
// Shared types and helpers for the AXI4 scratch-memory responder.
// Optional feature macro: AXI_SLV_MEM_WRAP_EN (enables WRAP bursts).
package axi_slv_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI_SLV_MEM_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'b00,
        R_FETCH = 2'b01,
        R_DATA  = 2'b10
    } rstate_e;

    // Address of the following beat; WRAP wraps inside a (len+1)*size window.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [7:0]  len,
                                              input burst_e      burst,
                                              input logic [31:0] size_bytes);
        logic [31:0] bound;
        bound = (32'(len) + 32'd1) * size_bytes;
        case (burst)
            BURST_INCR: next_addr = addr + size_bytes;
            BURST_WRAP: next_addr = (addr & ~(bound - 32'd1))
                                  | ((addr + size_bytes) & (bound - 32'd1));
            default:    next_addr = addr;
        endcase
    endfunction

    // True when this burst type/length combination is served.
    function automatic logic burst_ok(input burst_e burst, input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        case (burst)
            BURST_FIXED, BURST_INCR: burst_ok = 1'b1;
            BURST_WRAP:              burst_ok = WRAP_EN && wrap_len_ok;
            default:                 burst_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/axi_slv_mem_ram.sv
// Simple dual-port RAM: byte-enabled write port, read-first registered read port.
// The read register only updates when re is set, so it holds a beat stable.
module axi_slv_mem_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                re,
    input  logic                rzero,
    input  logic [AW-1:0]       raddr,
    output logic [DATA_W-1:0]   rdata
);

    localparam int unsigned STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read register; rzero substitutes zero data for error beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rzero ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/axi_slv_mem_responder.sv
// AXI4 slave backed by on-chip byte-writable memory; independent write and read FSMs.
// FIXED and INCR bursts always; WRAP only when AXI_SLV_MEM_WRAP_EN is defined.
module axi_slv_mem_responder
    import axi_slv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic [7:0]          s_awlen,
    input  logic [1:0]          s_awburst,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wlast,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic [7:0]          s_arlen,
    input  logic [1:0]          s_arburst,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                s_rvalid,
    input  logic                s_rready
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_W - OFF_W;
    localparam int unsigned RAM_AW = $clog2(MEM_DEPTH);

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return 32'(idx) < 32'(MEM_DEPTH);
    endfunction

    wstate_e           w_state;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len;
    logic [7:0]        w_cnt;
    burst_e            w_burst;
    logic              w_bad_burst;
    logic              w_err;

    rstate_e           r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    burst_e            r_burst;
    logic              r_bad_burst;

    logic              w_hs;
    logic              w_beat_err;
    logic              w_err_next;
    logic              w_at_len;
    logic              w_resp_err;
    logic              r_beat_err;
    logic              ram_we;
    logic              ram_re;
    logic [RAM_AW-1:0] ram_waddr;
    logic [RAM_AW-1:0] ram_raddr;

    // Per-beat error decode and memory port control.
    always_comb begin
        w_hs       = (w_state == W_DATA) && s_wvalid && s_wready;
        w_beat_err = w_bad_burst || !in_range(w_addr[ADDR_W-1:OFF_W]);
        w_err_next = w_err || w_beat_err;
        w_at_len   = (w_cnt == w_len);
        w_resp_err = w_err_next || (w_at_len && !s_wlast) || (s_wlast && !w_at_len);
        ram_we     = w_hs && !w_beat_err && !areset;
        ram_waddr  = RAM_AW'(w_addr[ADDR_W-1:OFF_W]);
        r_beat_err = r_bad_burst || !in_range(r_addr[ADDR_W-1:OFF_W]);
        ram_re     = (r_state == R_FETCH);
        ram_raddr  = RAM_AW'(r_addr[ADDR_W-1:OFF_W]);
    end

    // Write FSM: accept address, absorb data beats, return one response.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state     <= W_IDLE;
            w_addr      <= '0;
            w_len       <= '0;
            w_cnt       <= '0;
            w_burst     <= BURST_FIXED;
            w_bad_burst <= 1'b0;
            w_err       <= 1'b0;
            s_awready   <= 1'b0;
            s_wready    <= 1'b0;
            s_bvalid    <= 1'b0;
            s_bresp     <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    s_awready <= 1'b1;
                    if (s_awvalid && s_awready) begin
                        w_addr      <= s_awaddr;
                        w_len       <= s_awlen;
                        w_burst     <= burst_e'(s_awburst);
                        w_cnt       <= '0;
                        w_bad_burst <= !burst_ok(burst_e'(s_awburst), s_awlen);
                        w_err       <= 1'b0;
                        s_awready   <= 1'b0;
                        s_wready    <= 1'b1;
                        w_state     <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (w_at_len || s_wlast) begin
                            s_wready <= 1'b0;
                            s_bvalid <= 1'b1;
                            s_bresp  <= w_resp_err ? RESP_SLVERR : RESP_OKAY;
                            w_state  <= W_RESP;
                        end else begin
                            w_cnt  <= w_cnt + 8'd1;
                            w_addr <= ADDR_W'(next_addr(32'(w_addr), w_len, w_burst, 32'(STRB_W)));
                            w_err  <= w_err_next;
                        end
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        s_bvalid  <= 1'b0;
                        s_bresp   <= RESP_OKAY;
                        s_awready <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: one fetch cycle then one held data beat per memory word.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= R_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_burst     <= BURST_FIXED;
            r_bad_burst <= 1'b0;
            s_arready   <= 1'b0;
            s_rvalid    <= 1'b0;
            s_rresp     <= RESP_OKAY;
            s_rlast     <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s_arready <= 1'b1;
                    if (s_arvalid && s_arready) begin
                        r_addr      <= s_araddr;
                        r_len       <= s_arlen;
                        r_burst     <= burst_e'(s_arburst);
                        r_cnt       <= '0;
                        r_bad_burst <= !burst_ok(burst_e'(s_arburst), s_arlen);
                        s_arready   <= 1'b0;
                        r_state     <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    s_rvalid <= 1'b1;
                    s_rresp  <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
                    s_rlast  <= (r_cnt == r_len);
                    r_state  <= R_DATA;
                end
                R_DATA: begin
                    if (s_rready) begin
                        s_rvalid <= 1'b0;
                        s_rlast  <= 1'b0;
                        s_rresp  <= RESP_OKAY;
                        if (s_rlast) begin
                            s_arready <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 8'd1;
                            r_addr  <= ADDR_W'(next_addr(32'(r_addr), r_len, r_burst, 32'(STRB_W)));
                            r_state <= R_FETCH;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    axi_slv_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk    (aclk),
        .rst    (areset),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (s_wdata),
        .wstrb  (s_wstrb),
        .re     (ram_re),
        .rzero  (r_beat_err),
        .raddr  (ram_raddr),
        .rdata  (s_rdata)
    );

endmodule

// File: tb/tb_axi_slv_mem_responder.sv
// Directed bench for axi_slv_mem_responder; WRAP expectations follow AXI_SLV_MEM_WRAP_EN.
`timescale 1ns/1ps
module tb_axi_slv_mem_responder;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] RSVD   = 2'b11;

    logic        aclk = 1'b0;
    logic        areset;
    logic [15:0] s_awaddr;
    logic [7:0]  s_awlen;
    logic [1:0]  s_awburst;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [15:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [1:0]  s_arburst;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready;

    always #5 aclk = ~aclk;

    axi_slv_mem_responder #(.ADDR_W(16), .DATA_W(32), .MEM_DEPTH(1024)) dut (
        .aclk(aclk), .areset(areset),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    typedef struct {
        logic [15:0] waddr;
        logic [1:0]  wburst;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_b;
        logic [15:0] raddr;
        logic [1:0]  rburst;
        logic [31:0] exp_rd;
        logic [1:0]  exp_rr;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] wbuf  [16];
    logic [31:0] exp_d [16];
    logic [1:0]  exp_r [16];
    logic [1:0]  bresp_got;
    int          rd_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: handshake did not occur within 50 cycles", name);
    endtask

    // Waits (at negedges) for rvalid; ok=0 when the bound expires.
    task automatic wait_rvalid(output int waited, output bit ok);
        waited = 0;
        while (!s_rvalid && waited < 50) begin
            @(negedge aclk);
            waited++;
        end
        ok = s_rvalid;
    endtask

    // Full write burst from wbuf; nbeats may end early with wlast.
    task automatic axi_write(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input int nbeats, input logic [3:0] strb, input bit hold_b,
                             input logic [1:0] exp_b);
        int n;
        s_awaddr = addr; s_awlen = len; s_awburst = burst; s_awvalid = 1'b1;
        n = 0;
        while (!s_awready && n < 50) begin @(negedge aclk); n++; end
        if (!s_awready) begin timeout("aw_hs"); s_awvalid = 1'b0; return; end
        @(negedge aclk);
        s_awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            s_wdata = wbuf[i]; s_wstrb = strb; s_wlast = (i == nbeats - 1); s_wvalid = 1'b1;
            n = 0;
            while (!s_wready && n < 50) begin @(negedge aclk); n++; end
            if (!s_wready) begin timeout("w_hs"); s_wvalid = 1'b0; s_wlast = 1'b0; return; end
            @(negedge aclk);
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        n = 0;
        while (!s_bvalid && n < 50) begin @(negedge aclk); n++; end
        if (!s_bvalid) begin timeout("b_hs"); return; end
        if (hold_b) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge aclk);
                check("bvalid_hold", 32'(s_bvalid), 32'd1);
                check("bresp_hold", 32'(s_bresp), 32'(exp_b));
            end
        end
        bresp_got = s_bresp;
        s_bready = 1'b1;
        @(negedge aclk);
        s_bready = 1'b0;
    endtask

    // Read burst checked beat-by-beat against exp_d/exp_r; optional 5-cycle stall.
    task automatic axi_read(input string tag, input logic [15:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int stall_beat);
        int n;
        bit ok;
        s_araddr = addr; s_arlen = len; s_arburst = burst; s_arvalid = 1'b1;
        n = 0;
        while (!s_arready && n < 50) begin @(negedge aclk); n++; end
        if (!s_arready) begin timeout("ar_hs"); s_arvalid = 1'b0; return; end
        @(negedge aclk);
        s_arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wait_rvalid(n, ok);
            if (!ok) begin timeout("r_hs"); return; end
            if (i == 0) rd_lat = 1 + n;
            check($sformatf("%s_rdata%0d", tag, i), s_rdata, exp_d[i]);
            check($sformatf("%s_rresp%0d", tag, i), 32'(s_rresp), 32'(exp_r[i]));
            check($sformatf("%s_rlast%0d", tag, i), 32'(s_rlast), 32'(i == int'(len)));
            if (i == stall_beat) begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge aclk);
                    check("stall_rvalid", 32'(s_rvalid), 32'd1);
                    check("stall_rdata", s_rdata, exp_d[i]);
                    check("stall_rlast", 32'(s_rlast), 32'(i == int'(len)));
                end
            end
            s_rready = 1'b1;
            @(negedge aclk);
            s_rready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  ok;

        vecs[0] = '{16'h0010, INCR,  32'hDEADBEEF, 4'hF, OKAY,   16'h0010, INCR,  32'hDEADBEEF, OKAY};
        vecs[1] = '{16'h0020, INCR,  32'hFFFFFFFF, 4'hF, OKAY,   16'h0020, INCR,  32'hFFFFFFFF, OKAY};
        vecs[2] = '{16'h0020, INCR,  32'h00000000, 4'h5, OKAY,   16'h0020, INCR,  32'hFF00FF00, OKAY};
        vecs[3] = '{16'h1000, INCR,  32'h12345678, 4'hF, SLVERR, 16'h1000, INCR,  32'h00000000, SLVERR};
        vecs[4] = '{16'h0030, INCR,  32'h11223344, 4'hF, OKAY,   16'h0030, INCR,  32'h11223344, OKAY};
        vecs[5] = '{16'h0030, RSVD,  32'hAAAA5555, 4'hF, SLVERR, 16'h0030, INCR,  32'h11223344, OKAY};
        vecs[6] = '{16'h0042, INCR,  32'hCAFEF00D, 4'hF, OKAY,   16'h0040, INCR,  32'hCAFEF00D, OKAY};
        vecs[7] = '{16'h0FFC, INCR,  32'h01020304, 4'hF, OKAY,   16'h0FFC, FIXED, 32'h01020304, OKAY};
        vecs[8] = '{16'h0050, FIXED, 32'h00000055, 4'hF, OKAY,   16'h0050, RSVD,  32'h00000000, SLVERR};

        areset = 1'b1;
        s_awaddr = '0; s_awlen = '0; s_awburst = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_araddr = '0; s_arlen = '0; s_arburst = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (3) @(negedge aclk);

        check("rst_awready", 32'(s_awready), 32'd0);
        check("rst_wready",  32'(s_wready),  32'd0);
        check("rst_bvalid",  32'(s_bvalid),  32'd0);
        check("rst_bresp",   32'(s_bresp),   32'd0);
        check("rst_arready", 32'(s_arready), 32'd0);
        check("rst_rvalid",  32'(s_rvalid),  32'd0);
        check("rst_rresp",   32'(s_rresp),   32'd0);
        check("rst_rdata",   s_rdata,        32'd0);
        check("rst_rlast",   32'(s_rlast),   32'd0);

        areset = 1'b0;
        @(negedge aclk);
        check("idle_awready", 32'(s_awready), 32'd1);
        check("idle_arready", 32'(s_arready), 32'd1);

        // Single-beat write/read vectors.
        for (int i = 0; i < NVEC; i++) begin
            wbuf[0] = vecs[i].wdata;
            axi_write(vecs[i].waddr, 8'd0, vecs[i].wburst, 1, vecs[i].wstrb, 1'b0, vecs[i].exp_b);
            check($sformatf("v%0d_bresp", i), 32'(bresp_got), 32'(vecs[i].exp_b));
            exp_d[0] = vecs[i].exp_rd;
            exp_r[0] = vecs[i].exp_rr;
            axi_read($sformatf("v%0d", i), vecs[i].raddr, 8'd0, vecs[i].rburst, -1);
            check($sformatf("v%0d_rlat", i), 32'(rd_lat), 32'd2);
        end

        // INCR len=3 with B and R backpressure.
        for (int i = 0; i < 4; i++) begin
            wbuf[i]  = 32'(i + 1);
            exp_d[i] = 32'(i + 1);
            exp_r[i] = OKAY;
        end
        axi_write(16'h0100, 8'd3, INCR, 4, 4'hF, 1'b1, OKAY);
        check("incr_bresp", 32'(bresp_got), 32'(OKAY));
        axi_read("incr", 16'h0100, 8'd3, INCR, 1);

        // Early wlast on beat 2 of a len=3 burst.
        wbuf[0] = 32'h0000300A;
        wbuf[1] = 32'h0000300B;
        axi_write(16'h0300, 8'd3, INCR, 2, 4'hF, 1'b0, SLVERR);
        check("early_bresp", 32'(bresp_got), 32'(SLVERR));
        check("early_awready", 32'(s_awready), 32'd1);
        check("early_wready", 32'(s_wready), 32'd0);
        exp_d[0] = 32'h0000300A; exp_r[0] = OKAY;
        exp_d[1] = 32'h0000300B; exp_r[1] = OKAY;
        axi_read("early", 16'h0300, 8'd1, INCR, -1);

        // Reset in the middle of a read burst (beat 2 waiting).
        s_araddr = 16'h0100; s_arlen = 8'd3; s_arburst = INCR; s_arvalid = 1'b1;
        n = 0;
        while (!s_arready && n < 50) begin @(negedge aclk); n++; end
        @(negedge aclk);
        s_arvalid = 1'b0;
        wait_rvalid(n, ok);
        if (!ok) timeout("rst_r_hs0");
        s_rready = 1'b1;
        @(negedge aclk);
        s_rready = 1'b0;
        wait_rvalid(n, ok);
        if (!ok) timeout("rst_r_hs1");
        check("rst_beat2_data", s_rdata, 32'd2);
        areset = 1'b1;
        @(negedge aclk);
        check("midrst_rvalid",  32'(s_rvalid),  32'd0);
        check("midrst_rlast",   32'(s_rlast),   32'd0);
        check("midrst_rdata",   s_rdata,        32'd0);
        check("midrst_arready", 32'(s_arready), 32'd0);
        areset = 1'b0;
        @(negedge aclk);
        exp_d[0] = 32'hDEADBEEF; exp_r[0] = OKAY;
        axi_read("postrst", 16'h0010, 8'd0, INCR, -1);

        // WRAP len=3 read starting at 0x000C.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0A00000 + 32'(i);
        axi_write(16'h0000, 8'd3, INCR, 4, 4'hF, 1'b0, OKAY);
        check("wrapfill_bresp", 32'(bresp_got), 32'(OKAY));
`ifdef AXI_SLV_MEM_WRAP_EN
        exp_d[0] = 32'hA0A00003; exp_d[1] = 32'hA0A00000;
        exp_d[2] = 32'hA0A00001; exp_d[3] = 32'hA0A00002;
        for (int i = 0; i < 4; i++) exp_r[i] = OKAY;
`else
        for (int i = 0; i < 4; i++) begin
            exp_d[i] = 32'd0;
            exp_r[i] = SLVERR;
        end
`endif
        axi_read("wrap", 16'h000C, 8'd3, WRAP, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
